// File: rtl/adc_stimulus_gen.sv
// Parametrised ADC stand-in: round-robin channel samples on a fixed sample period,
// each with a multi-clock valid strobe and one of four selectable waveforms.
module adc_stimulus_gen #(
   parameter int                    DATA_WIDTH   = 12,
   parameter int                    NOISE_BITS   = 5,
   parameter int                    NUM_CHANNELS = 4,
   parameter int                    CLK_DIV      = 2000,
   parameter int                    VALID_CYCLES = 1,
   parameter logic [DATA_WIDTH-1:0] BASE_VALUE   = 12'h8C0,
   parameter int                    RAMP_STEP    = 1,
   localparam int                   CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                  MAX10_CLK1_50,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [1:0]            mode,
   output logic                  response_valid_out,
   output logic [CH_W-1:0]       channel_out,
   output logic [DATA_WIDTH-1:0] ADC_out
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int VC_W   = (VALID_CYCLES > 1) ? $clog2(VALID_CYCLES) : 1;
   localparam int STEP_W = DATA_WIDTH + CH_W + 1;

   localparam logic [DIV_W-1:0]      WAIT_LAST = DIV_W'(CLK_DIV - VALID_CYCLES - 1);
   localparam logic [VC_W-1:0]       VC_LAST   = VC_W'(VALID_CYCLES - 1);
   localparam logic [CH_W-1:0]       CH_LAST   = CH_W'(NUM_CHANNELS - 1);
   localparam logic [DATA_WIDTH-1:0] STEP_D    = DATA_WIDTH'(RAMP_STEP);
   localparam logic [DATA_WIDTH-1:0] MAX_D     = {DATA_WIDTH{1'b1}};
   localparam logic [DATA_WIDTH-1:0] TRI_HI    = MAX_D - STEP_D;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
   function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
      lfsr_step = {1'b0, cur[15:1]} ^ (cur[0] ? 16'hB400 : 16'h0000);
   endfunction

   state_t                 state_r, state_nxt_s;
   logic [DIV_W-1:0]       div_cnt_r, div_nxt_s;
   logic [VC_W-1:0]        vcnt_r, vcnt_nxt_s;
   logic                   valid_r, valid_nxt_s;
   logic                   load_s, advance_s;
   logic [CH_W-1:0]        ch_ptr_r, ch_r;
   logic [DATA_WIDTH-1:0]  adc_r;

   logic [NOISE_BITS-1:0]  noise_cnt_r [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]  ramp_acc_r  [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]  tri_acc_r   [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] tri_down_r;
   logic [15:0]            lfsr_r;

   logic [NOISE_BITS-1:0]  noise_nxt_s;
   logic [DATA_WIDTH-1:0]  step_s, ramp_nxt_s, tri_nxt_s, sample_s;
   logic                   tri_down_nxt_s;
   logic [15:0]            lfsr_nxt_s;

   // FSM state register.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state, period/strobe counters and load/advance strobes.
   always_comb begin
      state_nxt_s = state_r;
      div_nxt_s   = div_cnt_r;
      vcnt_nxt_s  = vcnt_r;
      valid_nxt_s = valid_r;
      load_s      = 1'b0;
      advance_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (enable) begin
               state_nxt_s = ST_WAIT;
               div_nxt_s   = {DIV_W{1'b0}};
            end else begin
               valid_nxt_s = 1'b0;
            end
         end
         ST_WAIT: begin
            if (!enable) begin
               state_nxt_s = ST_IDLE;
               div_nxt_s   = {DIV_W{1'b0}};
            end else if (div_cnt_r == WAIT_LAST) begin
               state_nxt_s = ST_EMIT;
               load_s      = 1'b1;
               valid_nxt_s = 1'b1;
               vcnt_nxt_s  = {VC_W{1'b0}};
            end else begin
               div_nxt_s = div_cnt_r + DIV_W'(1'b1);
            end
         end
         ST_EMIT: begin
            if (vcnt_r == VC_LAST) begin
               // A strobe already started always completes, even with enable low.
               state_nxt_s = enable ? ST_WAIT : ST_IDLE;
               valid_nxt_s = 1'b0;
               div_nxt_s   = {DIV_W{1'b0}};
               advance_s   = 1'b1;
            end else begin
               vcnt_nxt_s = vcnt_r + VC_W'(1'b1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            valid_nxt_s = 1'b0;
            div_nxt_s   = {DIV_W{1'b0}};
         end
      endcase
   end

   // Candidate next generator values for the current channel, one per mode.
   always_comb begin
      noise_nxt_s    = noise_cnt_r[ch_ptr_r] + NOISE_BITS'(1'b1);
      step_s         = DATA_WIDTH'(STEP_W'(RAMP_STEP) * (STEP_W'(ch_ptr_r) + STEP_W'(1'b1)));
      ramp_nxt_s     = ramp_acc_r[ch_ptr_r] + step_s;
      lfsr_nxt_s     = lfsr_step(lfsr_r);
      tri_nxt_s      = tri_acc_r[ch_ptr_r];
      tri_down_nxt_s = tri_down_r[ch_ptr_r];
      if (!tri_down_r[ch_ptr_r]) begin
         if (tri_acc_r[ch_ptr_r] > TRI_HI) begin
            tri_nxt_s      = MAX_D;
            tri_down_nxt_s = 1'b1;
         end else begin
            tri_nxt_s = tri_acc_r[ch_ptr_r] + STEP_D;
         end
      end else begin
         if (tri_acc_r[ch_ptr_r] < STEP_D) begin
            tri_nxt_s      = {DATA_WIDTH{1'b0}};
            tri_down_nxt_s = 1'b0;
         end else begin
            tri_nxt_s = tri_acc_r[ch_ptr_r] - STEP_D;
         end
      end
      case (mode)
         2'd0:    sample_s = {BASE_VALUE[DATA_WIDTH-1:NOISE_BITS], noise_nxt_s};
         2'd1:    sample_s = ramp_nxt_s;
         2'd2:    sample_s = {BASE_VALUE[DATA_WIDTH-1:NOISE_BITS], lfsr_nxt_s[NOISE_BITS-1:0]};
         2'd3:    sample_s = tri_nxt_s;
         default: sample_s = {DATA_WIDTH{1'b0}};
      endcase
   end

   // Counters, registered outputs and per-channel generator state.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (!reset_n) begin
         div_cnt_r  <= {DIV_W{1'b0}};
         vcnt_r     <= {VC_W{1'b0}};
         valid_r    <= 1'b0;
         ch_ptr_r   <= {CH_W{1'b0}};
         ch_r       <= {CH_W{1'b0}};
         adc_r      <= {DATA_WIDTH{1'b0}};
         tri_down_r <= {NUM_CHANNELS{1'b0}};
         lfsr_r     <= 16'hACE1;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            noise_cnt_r[i] <= {NOISE_BITS{1'b0}};
            ramp_acc_r[i]  <= {DATA_WIDTH{1'b0}};
            tri_acc_r[i]   <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         div_cnt_r <= div_nxt_s;
         vcnt_r    <= vcnt_nxt_s;
         valid_r   <= valid_nxt_s;
         if (load_s) begin
            adc_r <= sample_s;
            ch_r  <= ch_ptr_r;
            // Only the selected mode's generator moves on this sample.
            case (mode)
               2'd0: noise_cnt_r[ch_ptr_r] <= noise_nxt_s;
               2'd1: ramp_acc_r[ch_ptr_r]  <= ramp_nxt_s;
               2'd2: lfsr_r                <= lfsr_nxt_s;
               2'd3: begin
                  tri_acc_r[ch_ptr_r]  <= tri_nxt_s;
                  tri_down_r[ch_ptr_r] <= tri_down_nxt_s;
               end
               default: ;
            endcase
         end
         if (advance_s) begin
            ch_ptr_r <= (ch_ptr_r == CH_LAST) ? {CH_W{1'b0}} : ch_ptr_r + CH_W'(1'b1);
         end
      end
   end

   assign response_valid_out = valid_r;
   assign channel_out        = ch_r;
   assign ADC_out            = adc_r;

endmodule

// File: tb/tb_adc_stimulus_gen.sv
// Self-checking bench for adc_stimulus_gen: directed sequence plus random modes,
// compared against an arithmetic per-channel waveform model.
module tb_adc_stimulus_gen;

   localparam int DW    = 12;
   localparam int NCH   = 2;
   localparam int DIV   = 8;
   localparam int VC    = 2;
   localparam int BASE  = 32'h8C0;
   localparam int FIRST = DIV - VC + 1;

   logic        clk = 1'b0;
   logic        reset_n, enable1, enable2;
   logic [1:0]  mode1, mode2;
   logic        vld1, vld2;
   logic        ch1, ch2;
   logic [11:0] adc1, adc2;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // reference model state, [instance][channel]
   int unsigned m_noise [2][NCH];
   int unsigned m_ramp  [2][NCH];
   int unsigned m_tri   [2][NCH];
   bit          m_down  [2][NCH];
   int unsigned m_lfsr  [2];
   int          m_ch    [2];
   int          m_last_ch [2];
   int unsigned last_val [2];
   int          last_rise [2];

   adc_stimulus_gen #(.DATA_WIDTH(12), .NOISE_BITS(5), .NUM_CHANNELS(NCH), .CLK_DIV(DIV),
                      .VALID_CYCLES(VC), .BASE_VALUE(12'h8C0), .RAMP_STEP(1)) dut1 (
      .MAX10_CLK1_50(clk), .reset_n(reset_n), .enable(enable1), .mode(mode1),
      .response_valid_out(vld1), .channel_out(ch1), .ADC_out(adc1));

   adc_stimulus_gen #(.DATA_WIDTH(12), .NOISE_BITS(5), .NUM_CHANNELS(NCH), .CLK_DIV(DIV),
                      .VALID_CYCLES(VC), .BASE_VALUE(12'h8C0), .RAMP_STEP(1024)) dut2 (
      .MAX10_CLK1_50(clk), .reset_n(reset_n), .enable(enable2), .mode(mode2),
      .response_valid_out(vld2), .channel_out(ch2), .ADC_out(adc2));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic get_vld(input int i);
      return (i == 0) ? vld1 : vld2;
   endfunction

   function automatic logic [31:0] get_ch(input int i);
      return (i == 0) ? 32'(ch1) : 32'(ch2);
   endfunction

   function automatic logic [31:0] get_adc(input int i);
      return (i == 0) ? 32'(adc1) : 32'(adc2);
   endfunction

   function automatic void model_reset(input int i);
      for (int c = 0; c < NCH; c++) begin
         m_noise[i][c] = 0; m_ramp[i][c] = 0; m_tri[i][c] = 0; m_down[i][c] = 0;
      end
      m_lfsr[i] = 32'hACE1;
      m_ch[i]   = 0;
   endfunction

   // Next sample value for instance i under mode md; advances the channel pointer.
   function automatic int unsigned model_next(input int i, input int md, input int unsigned step);
      int          c;
      int unsigned v;
      int unsigned hi;
      c  = m_ch[i];
      hi = (BASE / 32) * 32;
      case (md)
         0: begin
            m_noise[i][c] = (m_noise[i][c] + 1) % 32;
            v = hi + m_noise[i][c];
         end
         1: begin
            m_ramp[i][c] = (m_ramp[i][c] + step * (c + 1)) % 4096;
            v = m_ramp[i][c];
         end
         2: begin
            if (m_lfsr[i] % 2 == 1) m_lfsr[i] = (m_lfsr[i] / 2) ^ 32'hB400;
            else                    m_lfsr[i] = m_lfsr[i] / 2;
            v = hi + (m_lfsr[i] % 32);
         end
         default: begin
            if (!m_down[i][c]) begin
               if (m_tri[i][c] + step > 4095) begin m_tri[i][c] = 4095; m_down[i][c] = 1; end
               else m_tri[i][c] = m_tri[i][c] + step;
            end else begin
               if (m_tri[i][c] < step) begin m_tri[i][c] = 0; m_down[i][c] = 0; end
               else m_tri[i][c] = m_tri[i][c] - step;
            end
            v = m_tri[i][c];
         end
      endcase
      m_last_ch[i] = c;
      m_ch[i] = (c + 1) % NCH;
      return v;
   endfunction

   task automatic set_enable(input int i, input logic v);
      if (i == 0) enable1 = v;
      else        enable2 = v;
   endtask

   // Wait for the next strobe of instance i, check it, and follow it to its end.
   task automatic expect_sample(input int i, input int md, input int unsigned step,
                                input int exp_lat, input bit chk_period, input bit drop_en);
      int          n;
      int          k;
      bit          got;
      int unsigned ev;
      n = 0; got = 0;
      while (!got && n < 3 * DIV) begin
         @(posedge clk); #1;
         n++;
         got = get_vld(i);
      end
      check("strobe_seen", 32'(got), 32'd1);
      if (got) begin
         if (drop_en) set_enable(i, 1'b0);
         ev = model_next(i, md, step);
         last_val[i] = ev;
         check("channel", get_ch(i), 32'(m_last_ch[i]));
         check("adc_value", get_adc(i), ev);
         if (exp_lat > 0) check("first_latency", 32'(n), 32'(exp_lat));
         if (chk_period)  check("period", 32'(cyc - last_rise[i]), 32'(DIV));
         last_rise[i] = cyc;
         k = 1;
         while (k <= VC) begin
            @(posedge clk); #1;
            if (!get_vld(i)) break;
            check("adc_stable", get_adc(i), ev);
            k++;
         end
         check("strobe_len", 32'(k), 32'(VC));
      end
   endtask

   task automatic expect_idle(input int i, input int cycles);
      int hi;
      hi = 0;
      for (int j = 0; j < cycles; j++) begin
         @(posedge clk); #1;
         if (get_vld(i)) hi++;
      end
      check("idle_no_strobe", 32'(hi), 32'd0);
      check("adc_held_idle", get_adc(i), last_val[i]);
   endtask

   int noise_tab [3] = '{32'h8C1, 32'h8C1, 32'h8C2};
   int ramp_tab  [7] = '{1024, 2048, 2048, 0, 3072, 2048, 0};
   int tri_tab   [9] = '{1024, 2048, 3072, 4095, 3071, 2047, 1023, 0, 1024};

   initial begin
      int md;
      int n;
      int t;
      reset_n = 1'b0; enable1 = 1'b0; enable2 = 1'b0; mode1 = 2'd0; mode2 = 2'd0;
      model_reset(0); model_reset(1);
      last_rise[0] = 0; last_rise[1] = 0; last_val[0] = 0; last_val[1] = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", 32'(vld1), 32'd0);
      check("reset_channel", 32'(ch1), 32'd0);
      check("reset_adc", 32'(adc1), 32'd0);
      check("reset_adc_dut2", 32'(adc2), 32'd0);
      reset_n = 1'b1;

      // first samples in counter-noise mode, including first-strobe latency
      enable1 = 1'b1;
      for (int s = 0; s < 3; s++) begin
         expect_sample(0, 0, 1, (s == 0) ? FIRST : 0, s != 0, 1'b0);
         check("noise_first", 32'(adc1), 32'(noise_tab[s]));
      end

      // long noise run: 5-bit counters wrap, upper bits fixed
      for (int s = 0; s < 64; s++) begin
         expect_sample(0, 0, 1, 0, 1'b1, 1'b0);
         check("noise_upper", 32'(adc1[11:5]), 32'(7'b1000110));
      end

      // enable dropped during the strobe: strobe completes, then idle
      expect_sample(0, 0, 1, 0, 1'b1, 1'b1);
      expect_idle(0, 3 * DIV);
      enable1 = 1'b1;
      expect_sample(0, 0, 1, FIRST, 1'b0, 1'b0);

      // enable dropped during the wait: no partial sample
      repeat (2) @(posedge clk);
      #1;
      enable1 = 1'b0;
      expect_idle(0, 3 * DIV);
      enable1 = 1'b1;
      expect_sample(0, 0, 1, FIRST, 1'b0, 1'b0);

      // random mode per sample, changed during the wait
      for (int s = 0; s < 40; s++) begin
         md = $urandom_range(0, 3);
         mode1 = 2'(md);
         expect_sample(0, md, 1, 0, 1'b1, 1'b0);
      end

      // reset in the middle of a strobe
      n = 0;
      while (!vld1 && n < 3 * DIV) begin
         @(posedge clk); #1;
         n++;
      end
      check("strobe_before_reset", 32'(vld1), 32'd1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("midemit_reset_valid", 32'(vld1), 32'd0);
      check("midemit_reset_adc", 32'(adc1), 32'd0);
      check("midemit_reset_channel", 32'(ch1), 32'd0);
      model_reset(0); model_reset(1);
      last_val[0] = 0;

      // first LFSR sample after reset, then switch back to counter noise mid-wait
      mode1 = 2'd2;
      reset_n = 1'b1;
      expect_sample(0, 2, 1, FIRST, 1'b0, 1'b0);
      check("lfsr_first", 32'(adc1), 32'h8D0);
      mode1 = 2'd0;
      expect_sample(0, 0, 1, 0, 1'b1, 1'b0);
      check("mode_switch_adc", 32'(adc1), 32'h8C1);
      check("mode_switch_ch", 32'(ch1), 32'd1);
      enable1 = 1'b0;

      // large-step instance: ramp wrap, then triangle
      mode2 = 2'd1;
      enable2 = 1'b1;
      for (int s = 0; s < 7; s++) begin
         expect_sample(1, 1, 1024, (s == 0) ? FIRST : 0, s != 0, 1'b0);
         check("ramp_table", 32'(adc2), 32'(ramp_tab[s]));
      end
      mode2 = 2'd3;
      t = 0;
      for (int s = 0; s < 18; s++) begin
         expect_sample(1, 3, 1024, 0, 1'b1, 1'b0);
         if (m_last_ch[1] == 0 && t < 9) begin
            check("triangle_table", 32'(adc2), 32'(tri_tab[t]));
            t++;
         end
      end
      enable2 = 1'b0;
      repeat (4) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
